// File: rtl/sdr_mult_pkg.sv
// Shared constants and types for the SDR datapath multiplier sharing logic.
// Purely declarative: no latency, no backpressure.
package sdr_mult_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MULT_LAT = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Requester ID width; never zero so NREQ=1 still yields a legal port.
    function automatic int REQ_ID_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request at or above the pointer, with wrap.
// Purely combinational, zero latency; no backpressure.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt_oh,
    output logic [IDW-1:0]  o_gnt_idx,
    output logic            o_gnt_any
);

    int w_cand;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = (int'(i_ptr) + i) % NREQ;
            if (!o_gnt_any && i_req[w_cand]) begin
                o_gnt_any        = 1'b1;
                o_gnt_oh[w_cand] = 1'b1;
                o_gnt_idx        = IDW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin (with lock) sharing of one pipelined signed multiplier between NREQ clients.
// Result returns 1+MULT_LAT+1 clk after grant, in grant order; no backpressure on results.
module mult_share_arbiter
    import sdr_mult_pkg::*;
#(
    parameter  int NREQ     = DEF_NREQ,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int MULT_LAT = DEF_MULT_LAT,
    localparam int IDW      = REQ_ID_W(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic [2*WIDTH-1:0]    mult_result,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [2*WIDTH-1:0]    res_data
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDW-1:0]      r_owner;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [WIDTH-1:0]    r_mult_a;
    logic [WIDTH-1:0]    r_mult_b;
    logic                r_tag_vld [0:MULT_LAT];
    logic [IDW-1:0]      r_tag_id  [0:MULT_LAT];
    logic                r_res_valid;
    logic [IDW-1:0]      r_res_id;
    logic [2*WIDTH-1:0]  r_res_data;

    logic [NREQ-1:0]     w_pick_oh;
    logic [IDW-1:0]      w_pick_idx;
    logic                w_pick_any;
    logic [NREQ-1:0]     w_gnt;
    logic [IDW-1:0]      w_gnt_idx;
    logic                w_gnt_vld;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_pick_oh),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_any (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_gnt_idx   = w_pick_idx;
        w_gnt_vld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_gnt     = w_pick_oh;
                    w_gnt_vld = 1'b1;
                    if (lock[w_pick_idx]) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // Owner keeps the multiplier while it asks; dropping req yields an idle cycle.
                if (req[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    w_gnt_idx      = r_owner;
                    w_gnt_vld      = 1'b1;
                    if (!lock[r_owner]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // While locked the owner is constant, so re-writing owner+1 each grant equals updating on the last one.
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            for (int s = 0; s <= MULT_LAT; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_id[0]  <= w_gnt_idx;
            for (int s = 1; s <= MULT_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            if (w_gnt_vld) begin
                r_owner  <= w_gnt_idx;
                r_ptr    <= w_ptr_nxt;
                r_mult_a <= a_in[w_gnt_idx*WIDTH +: WIDTH];
                r_mult_b <= b_in[w_gnt_idx*WIDTH +: WIDTH];
            end
            r_res_valid <= r_tag_vld[MULT_LAT];
            if (r_tag_vld[MULT_LAT]) begin
                r_res_id   <= r_tag_id[MULT_LAT];
                r_res_data <= mult_result;
            end
        end
    end

    assign gnt       = rst ? '0 : w_gnt;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural arbitration/latency model plus literal spot checks.
module tb_mult_share_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MULT_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [3:0]  gnt;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_result = '0;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .a_in        (a_in),
        .b_in        (b_in),
        .gnt         (gnt),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_data    (res_data)
    );

    // Stand-in for the vendor multiplier: one register stage, signed 8x8.
    always @(posedge clk)
        mult_result <= {{8{mult_a[7]}}, mult_a} * {{8{mult_b[7]}}, mult_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [15:0] prod;
    } res_t;

    res_t        exp_q[$];
    res_t        m_r;
    int          m_cyc = 0;
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_owner = 0;
    int          m_g;
    logic [3:0]  m_eg;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [7:0]  m_sa;
    logic [7:0]  m_sb;
    bit          m_expv;

    always @(negedge clk) begin
        m_g  = -1;
        m_eg = '0;
        if (rst) begin
            exp_q.delete();
            m_ptr    = 0;
            m_locked = 0;
            m_a      = '0;
            m_b      = '0;
        end else if (m_locked) begin
            if (req[m_owner]) m_g = m_owner;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (m_g < 0 && req[(m_ptr + i) % NREQ]) m_g = (m_ptr + i) % NREQ;
        end
        if (m_g >= 0) m_eg[m_g] = 1'b1;

        check("gnt", gnt, m_eg);
        check("mult_a", mult_a, m_a);
        check("mult_b", mult_b, m_b);
        m_expv = (exp_q.size() > 0) && (exp_q[0].cyc == m_cyc);
        check("res_valid", res_valid, m_expv);
        if (m_expv) begin
            m_r = exp_q.pop_front();
            check("res_id", res_id, m_r.id);
            check("res_data", res_data, m_r.prod);
        end else if (rst) begin
            check("rst_res_id", res_id, 0);
            check("rst_res_data", res_data, 0);
        end

        if (m_g >= 0) begin
            m_sa     = a_in[m_g*8 +: 8];
            m_sb     = b_in[m_g*8 +: 8];
            m_r.cyc  = m_cyc + 1 + MULT_LAT + 1;
            m_r.id   = 2'(m_g);
            m_r.prod = {{8{m_sa[7]}}, m_sa} * {{8{m_sb[7]}}, m_sb};
            exp_q.push_back(m_r);
            m_a      = m_sa;
            m_b      = m_sb;
            m_ptr    = (m_g + 1) % NREQ;
            m_locked = lock[m_g];
            m_owner  = m_g;
        end else begin
            m_locked = 0;
        end
        m_cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] rq, input logic [3:0] lk,
                        input logic [31:0] a, input logic [31:0] b, input logic r);
        @(posedge clk);
        #1;
        req = rq; lock = lk; a_in = a; b_in = b; rst = r;
        #2;
    endtask

    logic [3:0]  g_seq [0:7];
    logic        v_seq [0:7];
    logic [1:0]  i_seq [0:7];
    logic [15:0] d_seq [0:7];
    bit          pend  [0:3];
    int          wait_c [0:3];
    int          max_wait_free;
    int          max_wait_lock;
    int          waited;
    logic [3:0]  rq_r;
    logic [3:0]  lk_r;

    initial begin
        step(4'hF, 4'h0, 32'h0, 32'h0, 1'b1);
        check("rst_gnt", gnt, 4'h0);
        check("rst_mult_a", mult_a, 8'h00);
        check("rst_res_valid", res_valid, 1'b0);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // single client 5 * -3
        step(4'h1, 4'h0, 32'h5, 32'hFD, 1'b0);
        check("single_gnt", gnt, 4'h1);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("single_early", res_valid, 1'b0);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("single_vld", res_valid, 1'b1);
        check("single_id", res_id, 2'd0);
        check("single_data", res_data, 16'hFFF1);

        // all four requesting, a=i+1, b=2
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b1);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 4'h0, 32'h04030201, 32'h02020202, 1'b0);
            g_seq[i] = gnt; v_seq[i] = res_valid; i_seq[i] = res_id; d_seq[i] = res_data;
        end
        for (int i = 0; i < 5; i++) check("rr_gnt", g_seq[i], 32'(1 << (i % 4)));
        for (int i = 3; i < 7; i++) begin
            check("rr_vld", v_seq[i], 1'b1);
            check("rr_id", i_seq[i], i - 3);
            check("rr_data", d_seq[i], 2 * (i - 2));
        end

        // lock pair on requester 2 with requester 1 competing
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b1);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        step(4'b0010, 4'h0, 32'h0, 32'h0, 1'b0);
        check("lk_pre_gnt", gnt, 4'b0010);
        step(4'b0110, 4'b0100, 32'h00640000, 32'h00640000, 1'b0);
        check("lk_gnt0", gnt, 4'b0100);
        step(4'b0110, 4'b0000, 32'h00CE0000, 32'h00CE0000, 1'b0);
        check("lk_gnt1", gnt, 4'b0100);
        step(4'b0010, 4'h0, 32'h0, 32'h0, 1'b0);
        check("lk_gnt2", gnt, 4'b0010);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("lk_res0_id", res_id, 2'd2);
        check("lk_res0", res_data, 16'h2710);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("lk_res1_id", res_id, 2'd2);
        check("lk_res1", res_data, 16'h09C4);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("lk_res2_id", res_id, 2'd1);

        // extreme operands
        step(4'h1, 4'h0, 32'h80, 32'h80, 1'b0);
        check("ext_gnt0", gnt, 4'h1);
        step(4'h1, 4'h0, 32'h80, 32'h7F, 1'b0);
        check("ext_gnt1", gnt, 4'h1);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("ext_mm", res_data, 16'h4000);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("ext_mp", res_data, 16'hC080);

        // reset one cycle after a grant
        step(4'hF, 4'h0, 32'h11223344, 32'h55667788, 1'b0);
        step(4'hF, 4'h0, 32'h11223344, 32'h55667788, 1'b1);
        check("mid_rst_gnt", gnt, 4'h0);
        check("mid_rst_ma", mult_a, 8'h00);
        check("mid_rst_mb", mult_b, 8'h00);
        check("mid_rst_data", res_data, 16'h0000);
        step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
            check("mid_rst_novld", res_valid, 1'b0);
        end
        step(4'hF, 4'h0, 32'h0, 32'h0, 1'b0);
        check("post_rst_gnt", gnt, 4'h1);

        // late arrival of requester 1 while 3 requests continuously
        step(4'b1000, 4'h0, 32'h0, 32'h0, 1'b0);
        step(4'b1000, 4'h0, 32'h0, 32'h0, 1'b0);
        waited = 0;
        for (int i = 0; i < 2 * NREQ; i++) begin
            step(4'b1010, 4'h0, 32'h0, 32'h0, 1'b0);
            if (gnt[1]) break;
            waited++;
        end
        check("late_wait_ok", waited <= NREQ, 1'b1);

        // randomized traffic; req held until granted; lock only in second half
        for (int i = 0; i < 4; i++) begin pend[i] = 0; wait_c[i] = 0; end
        max_wait_free = 0;
        max_wait_lock = 0;
        for (int c = 0; c < 1000; c++) begin
            rq_r = '0;
            lk_r = '0;
            for (int i = 0; i < 4; i++) begin
                rq_r[i] = pend[i];
                lk_r[i] = (c >= 500) && ($urandom_range(3) == 0);
            end
            step(rq_r, lk_r, $urandom, $urandom, 1'b0);
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    if (gnt[i]) begin
                        if (c < 500 && wait_c[i] > max_wait_free) max_wait_free = wait_c[i];
                        if (c >= 500 && wait_c[i] > max_wait_lock) max_wait_lock = wait_c[i];
                        wait_c[i] = 0;
                        pend[i]   = ($urandom_range(1) == 1);
                    end else begin
                        wait_c[i]++;
                    end
                end else begin
                    pend[i]   = ($urandom_range(2) == 0);
                    wait_c[i] = 0;
                end
            end
        end
        check("fair_nolock", max_wait_free <= NREQ - 1, 1'b1);
        check("fair_lock", max_wait_lock <= 32, 1'b1);

        for (int i = 0; i < 5; i++) step(4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Time-shares one signed 8x8 pipelined multiplier (the vendor Multiplier primitive) between up to NREQ datapath clients: AM demod I²/Q², the mixer and the FIR MAC.
- Round-robin arbitration, one operand pair issued per clk.
- Result returned with the requester ID after the fixed pipeline latency.
- Lock option lets a client issue back-to-back pairs, e.g. I² then Q², with no interleaving.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH signed.
- MULT_LAT, 1, clk cycles from mult_a/mult_b registered to mult_result valid (the primitive's register depth).

Ports:
- clk  in  1  system clock (all logic on posedge).
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester operation request; held until granted.
- lock  in  NREQ  per-requester: keep grant for next cycle if req still high.
- a_in  in  NREQ*WIDTH  packed signed operand A (slice i = requester i).
- b_in  in  NREQ*WIDTH  packed signed operand B.
- gnt  out  NREQ  one-hot combinational grant this cycle.
- mult_a  out  WIDTH  registered operand A to multiplier DataA.
- mult_b  out  WIDTH  registered operand B to multiplier DataB.
- mult_result  in  2*WIDTH  multiplier Result.
- res_valid  out  1  result strobe, one clk.
- res_id  out  clog2(NREQ)  requester that owns res_data.
- res_data  out  2*WIDTH  signed product.

Behaviour:
- Reset (async, immediate):
  - Outputs: gnt=0, mult_a=0, mult_b=0, res_valid=0, res_id=0, res_data=0.
  - Internal: rr pointer=0, state=IDLE, tag pipeline valid bits all 0.
- FSM states:
  - IDLE: no owner. Grant the first requester with req high, searching from the rr pointer upward with wrap-around. Go to LOCKED if that requester's lock is high, else stay in IDLE.
  - LOCKED(owner): gnt=owner while req[owner]=1. Leave to IDLE when req[owner]=0 or lock[owner]=0 in the granted cycle.
    - If req[owner]=0: gnt=0 that cycle; arbitration resumes next cycle.
- Round robin:
  - After each grant to requester k, rr pointer = (k+1) mod NREQ.
  - In LOCKED state the pointer updates only on the final granted cycle.
- Grant cycle t (gnt[k]=1):
  - At posedge end of t: mult_a<=a_in[k], mult_b<=b_in[k].
  - Tag pipeline stage 0 <= {valid=1, id=k}; tag shifts MULT_LAT stages.
  - No grant in t: stage 0 valid=0; mult_a/mult_b hold.
- Latency:
  - res_valid rises exactly 1+MULT_LAT+1 cycles after the grant cycle: operand reg + multiplier + output reg.
  - res_data<=mult_result and res_id<=tag id in that same registered stage.
  - Fully pipelined: throughput one result per clk.
- Ordering: results emerge in grant order; no reordering, no backpressure (clients must accept res_valid).
- Arithmetic: operands and product are two's-complement. -128*-128 = +16384 (0x4000); no saturation needed.
- Boundary conditions:
  - No requests: gnt=0, tag bubbles, res_valid stays 0.
  - All NREQ requesting continuously, no lock: grants cycle 0,1,2,3,0,... exactly one per clk.
  - Requester dropping req in the grant cycle: still granted; the op is issued.
  - req rising for a requester already behind the pointer: served after the wrap.
  - rst asserted mid-stream: in-flight ops discarded, no res_valid after rst deasserts until a new grant plus latency.
  - NREQ=1: always grant requester 0 when req high.

Decomposition:
- Package sdr_mult_pkg:
  - REQ_ID_W function (clog2).
  - State encoding localparams ST_IDLE, ST_LOCKED.
  - Default WIDTH/MULT_LAT constants shared with AM demod and FIR.
- One natural sub-module: rr_priority_pick. Combinational; takes req vector and pointer, returns one-hot grant plus encoded index.
- The tag shift pipeline stays inline.
- Multiplier primitive is instantiated by the parent, not inside this block.

Test Plan:
- Single client: req[0]=1 for one cycle, a=5, b=-3 → gnt[0] that cycle; res_valid 3 cycles later (MULT_LAT=1) with res_id=0, res_data=0xFFF1 (-15).
- Four clients always requesting, a_in[i]=i+1, b_in=2 → grant order 0,1,2,3,0; results 2,4,6,8 with res_id 0..3 in order, one per clk.
- Lock pair: req[2]=1, lock[2]=1 for the 1st cycle, then lock=0; I=100 then Q=-50; req[1] also high → two consecutive gnt[2], then gnt[1]. Results 10000 (0x2710) then 2500 (0x09C4), both id=2.
- Extreme: a=-128, b=-128 → 0x4000; a=-128, b=127 → 0xC080 (-16256).
- Reset mid-pipeline: rst pulse one cycle after a grant → res_valid never asserts for that op; outputs 0 immediately; the next grant is requester 0 when all request.
- Fairness with late arrival: req[3] high continuously, req[1] rises after pointer passes 1 → req[1] served within NREQ cycles; no requester starves over 1000 random-req cycles.
